// File: rtl/lmsm_pkg.sv
// Shared types and default sizes for the LM/SM transfer sequencer.
package lmsm_pkg;

    localparam int LMSM_NREG = 8;
    localparam int LMSM_AW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } lmsm_state_e;

endpackage

// File: rtl/lmsm_sequencer_penc.sv
// Priority encoder over the remaining LM/SM mask: picks the lowest-numbered
// register (mask MSB = R0), its one-hot clear bit, and a single-bit-left flag.
module lmsm_penc
    import lmsm_pkg::*;
#(
    parameter int NREG = LMSM_NREG,
    parameter int RW   = $clog2(NREG)
) (
    input  logic [NREG-1:0] mask_i,
    output logic [RW-1:0]   idx_o,
    output logic [NREG-1:0] clr_o,
    output logic            single_o
);

    // Scanning upward lets the highest set bit (lowest register) win.
    always_comb begin
        idx_o = '0;
        clr_o = '0;
        for (int i = 0; i < NREG; i++) begin
            if (mask_i[i]) begin
                idx_o    = RW'(NREG - 1 - i);
                clr_o    = '0;
                clr_o[i] = 1'b1;
            end
        end
    end

    assign single_o = (mask_i != '0) && ((mask_i & (mask_i - NREG'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: accepts one instruction, issues one transfer per handshake.
// Optional base-writeback outputs are enabled by defining LMSM_BASE_WB_EN.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int NREG = LMSM_NREG,
    parameter int AW   = LMSM_AW,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic            start_is_store,
    input  logic [NREG-1:0] start_mask,
    input  logic [AW-1:0]   start_base,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [RW-1:0]   op_reg,
    output logic [AW-1:0]   op_addr,
    output logic            op_is_store,
    output logic            op_last,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            mask_zero,
`ifdef LMSM_BASE_WB_EN
    output logic            wb_valid,
    output logic [AW-1:0]   wb_addr,
`endif
    output lmsm_state_e     dbg_state
);

    // Handshakes: a transfer moves on a rising edge where op_valid && op_ready
    // and flush is low; an instruction is taken where start_valid && start_ready
    // and flush is low. op_* hold stable while op_valid waits for op_ready.

    lmsm_state_e     state_q, state_d;
    logic [NREG-1:0] mask_q, mask_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            store_q, store_d;
    logic            mzero_q, mzero_d;

    logic [RW-1:0]   pe_idx;
    logic [NREG-1:0] pe_clr;
    logic            pe_single;

    lmsm_penc #(.NREG(NREG), .RW(RW)) u_penc (
        .mask_i   (mask_q),
        .idx_o    (pe_idx),
        .clr_o    (pe_clr),
        .single_o (pe_single)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
            mzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            mzero_q <= mzero_d;
        end
    end

    // addr_q tracks base + k directly, so no separate ordinal counter is kept.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        store_d = store_q;
        mzero_d = mzero_q;
        if (flush) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            mzero_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        mask_d  = start_mask;
                        addr_d  = start_base;
                        store_d = start_is_store;
                        mzero_d = (start_mask == '0);
                        state_d = (start_mask == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_ready) begin
                        mask_d = mask_q & ~pe_clr;
                        addr_d = addr_q + AW'(1);
                        if (pe_single) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    mzero_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    logic issuing;
    assign issuing     = (state_q == ST_ISSUE);
    assign start_ready = (state_q == ST_IDLE);
    assign op_valid    = issuing;
    assign op_reg      = issuing ? pe_idx : '0;
    assign op_addr     = issuing ? addr_q : '0;
    assign op_is_store = issuing & store_q;
    assign op_last     = issuing & pe_single;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign mask_zero   = mzero_q;
    assign dbg_state   = state_q;

`ifdef LMSM_BASE_WB_EN
    // On reaching DONE addr_q has advanced once per set bit: base + popcount.
    assign wb_valid = (state_q == ST_DONE);
    assign wb_addr  = (state_q == ST_DONE) ? addr_q : '0;
`endif

endmodule
